// File: rtl/hwpe_ctrl_offload_arbiter_pkg.sv
// Shared constants and types for the HWPE control-port offload arbiter.
// Register indices alias the mandatory HWPE control slave registers.
package hwpe_ctrl_offload_arbiter_pkg;

  localparam int LOG_REGS = 5;

  localparam logic [LOG_REGS-1:0] REG_TRIGGER   = LOG_REGS'(0);
  localparam logic [LOG_REGS-1:0] REG_ACQUIRE   = LOG_REGS'(1);
  localparam logic [LOG_REGS-1:0] REG_SOFTCLEAR = LOG_REGS'(5);

  typedef enum logic [1:0] {
    ARB_UNLOCKED = 2'd0,
    ARB_ACQ_PEND = 2'd1,
    ARB_LOCKED   = 2'd2
  } arb_lock_state_e;

endpackage

// File: rtl/hwpe_ctrl_rr_arbiter.sv
// Masked round-robin winner selection: first eligible index at or after ptr_i,
// wrapping. Purely combinational so it can be reused in other arbiters.
module hwpe_ctrl_rr_arbiter #(
  parameter  int N     = 4,
  localparam int LOG_N = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic [LOG_N-1:0] ptr_i,
  output logic             valid_o,
  output logic [LOG_N-1:0] winner_o
);

  logic [N-1:0]     elig;
  logic [LOG_N-1:0] idx;
  logic             found;

  always_comb begin
    elig     = req_i & mask_i;
    valid_o  = |elig;
    winner_o = '0;
    idx      = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = LOG_N'((int'(ptr_i) + k) % N);
      if (!found && elig[idx]) begin
        found    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/hwpe_ctrl_offload_arbiter.sv
// Shares one HWPE control slave port between N_CORES cores with round-robin
// arbitration and an offload lock. Optional stale-lock release: HWPE_CTRL_ARB_LOCK_TIMEOUT_EN.
module hwpe_ctrl_offload_arbiter
  import hwpe_ctrl_offload_arbiter_pkg::*;
#(
  parameter  int N_CORES      = 4,
  parameter  int ADDR_WIDTH   = 32,
  parameter  int DATA_WIDTH   = 32,
  parameter  int LOCK_TIMEOUT = 1024,
  localparam int LOG_N        = $clog2(N_CORES)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [N_CORES-1:0]                      core_req_i,
  input  logic [N_CORES-1:0][ADDR_WIDTH-1:0]      core_add_i,
  input  logic [N_CORES-1:0]                      core_wen_i,
  input  logic [N_CORES-1:0][DATA_WIDTH/8-1:0]    core_be_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0]      core_data_i,
  output logic [N_CORES-1:0]                      core_gnt_o,
  output logic [DATA_WIDTH-1:0]                   core_r_data_o,
  output logic [N_CORES-1:0]                      core_r_valid_o,
  output logic                                    slv_req_o,
  output logic [ADDR_WIDTH-1:0]                   slv_add_o,
  output logic                                    slv_wen_o,
  output logic [DATA_WIDTH/8-1:0]                 slv_be_o,
  output logic [DATA_WIDTH-1:0]                   slv_data_o,
  output logic [N_CORES-1:0]                      slv_id_o,
  input  logic                                    slv_gnt_i,
  input  logic [DATA_WIDTH-1:0]                   slv_r_data_i,
  input  logic                                    slv_r_valid_i,
  output logic                                    locked_o,
  output logic [LOG_N-1:0]                        lock_owner_o,
`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
  output logic                                    lock_timeout_o,
`endif
  output arb_lock_state_e                         lock_state_o
);

  logic [N_CORES-1:0]  soft_req, mask;
  logic                any_elig, xfer, win_wen;
  logic [LOG_N-1:0]    winner;
  logic [LOG_REGS-1:0] win_reg;

  arb_lock_state_e     state_q, state_d;
  logic [LOG_N-1:0]    rr_ptr_q, rr_ptr_d, resp_idx_q, resp_idx_d, owner_q, owner_d;
  logic                resp_pend_q, resp_pend_d;

  // While locked only the owner competes, but SOFTCLEAR writes always get through.
  always_comb begin
    soft_req = '0;
    for (int i = 0; i < N_CORES; i++) begin
      soft_req[i] = !core_wen_i[i] && (core_add_i[i][LOG_REGS+1:2] == REG_SOFTCLEAR);
    end
    mask = '1;
    if (state_q != ARB_UNLOCKED) begin
      mask          = soft_req;
      mask[owner_q] = 1'b1;
    end
  end

  hwpe_ctrl_rr_arbiter #(.N(N_CORES)) u_rr (
    .req_i    (core_req_i),
    .mask_i   (mask),
    .ptr_i    (rr_ptr_q),
    .valid_o  (any_elig),
    .winner_o (winner)
  );

  assign xfer    = any_elig & slv_gnt_i;
  assign win_reg = core_add_i[winner][LOG_REGS+1:2];
  assign win_wen = core_wen_i[winner];

  always_comb begin
    slv_req_o  = any_elig;
    slv_add_o  = core_add_i[winner];
    slv_wen_o  = core_wen_i[winner];
    slv_be_o   = core_be_i[winner];
    slv_data_o = core_data_i[winner];
    slv_id_o   = '0;
    core_gnt_o = '0;
    if (any_elig) begin
      slv_id_o[winner]   = 1'b1;
      core_gnt_o[winner] = slv_gnt_i;
    end
    // A response only exists for a transfer granted since the last reset.
    core_r_valid_o = '0;
    if (slv_r_valid_i && resp_pend_q) core_r_valid_o[resp_idx_q] = 1'b1;
  end

  assign core_r_data_o = slv_r_data_i;

`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             to_pulse_q, to_pulse_d;
  logic             owner_xfer;

  assign owner_xfer = xfer && (winner == owner_q);

  always_comb begin
    to_cnt_d = '0;
    if (state_q == ARB_LOCKED && !owner_xfer) to_cnt_d = to_cnt_q + CNT_W'(1);
  end

  assign lock_timeout_o = to_pulse_q;
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = ^LOCK_TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    resp_pend_d = xfer;
    resp_idx_d  = xfer ? winner : resp_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) rr_ptr_d = (winner == LOG_N'(N_CORES - 1)) ? '0 : winner + LOG_N'(1);
`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
    to_pulse_d  = 1'b0;
`endif
    case (state_q)
      ARB_UNLOCKED: begin
        if (xfer && win_wen && win_reg == REG_ACQUIRE) begin
          state_d = ARB_ACQ_PEND;
          owner_d = winner;
        end
      end
      ARB_ACQ_PEND: begin
        // MSB set in the acquire read data means the engine has no free job slot.
        if (slv_r_valid_i) state_d = slv_r_data_i[DATA_WIDTH-1] ? ARB_UNLOCKED : ARB_LOCKED;
      end
      ARB_LOCKED: begin
        if (xfer && !win_wen && win_reg == REG_TRIGGER && winner == owner_q) state_d = ARB_UNLOCKED;
`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
        else if (!owner_xfer && to_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d    = ARB_UNLOCKED;
          to_pulse_d = 1'b1;
        end
`endif
      end
      default: state_d = ARB_UNLOCKED;
    endcase
    if (xfer && !win_wen && win_reg == REG_SOFTCLEAR) state_d = ARB_UNLOCKED;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_UNLOCKED;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      resp_idx_q  <= '0;
      resp_pend_q <= 1'b0;
`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
      to_cnt_q    <= '0;
      to_pulse_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_idx_q  <= resp_idx_d;
      resp_pend_q <= resp_pend_d;
`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      to_pulse_q  <= to_pulse_d;
`endif
    end
  end

  assign locked_o     = (state_q != ARB_UNLOCKED);
  assign lock_owner_o = owner_q;
  assign lock_state_o = state_q;

endmodule

// File: tb/tb_hwpe_ctrl_offload_arbiter.sv
// Bench for hwpe_ctrl_offload_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model of arbitration and locking.
module tb_hwpe_ctrl_offload_arbiter;
  import hwpe_ctrl_offload_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int LT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]         core_req_i, core_wen_i;
  logic [N-1:0][AW-1:0] core_add_i;
  logic [N-1:0][BW-1:0] core_be_i;
  logic [N-1:0][DW-1:0] core_data_i;
  logic [N-1:0]         core_gnt_o, core_r_valid_o, slv_id_o;
  logic [DW-1:0]        core_r_data_o, slv_data_o, slv_r_data_i;
  logic                 slv_req_o, slv_wen_o, slv_gnt_i, slv_r_valid_i, locked_o;
  logic [AW-1:0]        slv_add_o;
  logic [BW-1:0]        slv_be_o;
  logic [1:0]           lock_owner_o;
  arb_lock_state_e      lock_state;
`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
  logic                 lock_timeout_o;
`endif

  hwpe_ctrl_offload_arbiter #(
    .N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req_i), .core_add_i(core_add_i), .core_wen_i(core_wen_i),
    .core_be_i(core_be_i), .core_data_i(core_data_i),
    .core_gnt_o(core_gnt_o), .core_r_data_o(core_r_data_o), .core_r_valid_o(core_r_valid_o),
    .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
    .slv_be_o(slv_be_o), .slv_data_o(slv_data_o), .slv_id_o(slv_id_o),
    .slv_gnt_i(slv_gnt_i), .slv_r_data_i(slv_r_data_i), .slv_r_valid_i(slv_r_valid_i),
    .locked_o(locked_o), .lock_owner_o(lock_owner_o),
`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
    .lock_timeout_o(lock_timeout_o),
`endif
    .lock_state_o(lock_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    core_req_i = '0; core_wen_i = '0; core_add_i = '0; core_be_i = '0; core_data_i = '0;
    slv_gnt_i = 1'b0; slv_r_valid_i = 1'b0; slv_r_data_i = '0;
  endtask

  task automatic set_core(input int i, input bit wen, input logic [LOG_REGS-1:0] r);
    logic [AW-1:0] a;
    a = $urandom;
    a[LOG_REGS+1:2] = r;
    core_req_i[i] = 1'b1; core_wen_i[i] = wen; core_add_i[i] = a;
    core_be_i[i] = BW'($urandom); core_data_i[i] = $urandom;
  endtask

  task automatic drop_core(input int i);
    core_req_i[i] = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    slv_gnt_i = 1'b1;
  endtask

  // Slave with fixed 1-cycle read latency; acquire reads answer busy/free via MSB.
  task automatic advance(input bit xfer, input bit acq, input bit fail);
    @(posedge clk); #1;
    slv_r_valid_i = xfer;
    slv_r_data_i  = acq ? (fail ? '1 : '0) : DW'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    n_vec++; if (slv_req_o !== 1'b0) begin n_err++; $display("FAIL reset_slv_req got %b want 0", slv_req_o); end
    n_vec++; if (core_gnt_o !== 4'b0) begin n_err++; $display("FAIL reset_gnt got %b want 0000", core_gnt_o); end
    n_vec++; if (core_r_valid_o !== 4'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0000", core_r_valid_o); end
    n_vec++; if (slv_id_o !== 4'b0) begin n_err++; $display("FAIL reset_id got %b want 0000", slv_id_o); end
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", locked_o); end
    n_vec++; if (lock_owner_o !== 2'd0) begin n_err++; $display("FAIL reset_owner got %0d want 0", lock_owner_o); end
    n_vec++; if (lock_state !== ARB_UNLOCKED) begin n_err++; $display("FAIL reset_state got %0d want unlocked", lock_state); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    set_core(0, 1'b1, 3); set_core(2, 1'b1, 3);
    @(negedge clk);
    n_vec++; if (core_gnt_o !== 4'b0001) begin n_err++; $display("FAIL sim_gnt_t got %b want 0001", core_gnt_o); end
    n_vec++; if (slv_id_o !== 4'b0001) begin n_err++; $display("FAIL sim_id_t got %b want 0001", slv_id_o); end
    n_vec++; if (slv_add_o !== core_add_i[0]) begin n_err++; $display("FAIL sim_add_t got %h want %h", slv_add_o, core_add_i[0]); end
    advance(1, 0, 0); drop_core(0);
    @(negedge clk);
    n_vec++; if (core_gnt_o !== 4'b0100) begin n_err++; $display("FAIL sim_gnt_t1 got %b want 0100", core_gnt_o); end
    n_vec++; if (core_r_valid_o !== 4'b0001) begin n_err++; $display("FAIL sim_rvalid_t1 got %b want 0001", core_r_valid_o); end
    n_vec++; if (slv_add_o !== core_add_i[2]) begin n_err++; $display("FAIL sim_add_t1 got %h want %h", slv_add_o, core_add_i[2]); end
    advance(1, 0, 0); drop_core(2);
    @(negedge clk);
    n_vec++; if (core_r_valid_o !== 4'b0100) begin n_err++; $display("FAIL sim_rvalid_t2 got %b want 0100", core_r_valid_o); end
    n_vec++; if (core_gnt_o !== 4'b0000) begin n_err++; $display("FAIL sim_gnt_t2 got %b want 0000", core_gnt_o); end
    advance(0, 0, 0);
  endtask

  task automatic test_lock_trigger();
    apply_reset();
    set_core(1, 1'b1, REG_ACQUIRE); set_core(3, 1'b0, 8);
    @(negedge clk);
    n_vec++; if (core_gnt_o !== 4'b0010) begin n_err++; $display("FAIL lk_acq_gnt got %b want 0010", core_gnt_o); end
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL lk_acq_locked got %b want 0", locked_o); end
    advance(1, 1, 0); set_core(1, 1'b0, 8);
    @(negedge clk);
    n_vec++; if (core_gnt_o !== 4'b0010) begin n_err++; $display("FAIL lk_wr_gnt got %b want 0010", core_gnt_o); end
    n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL lk_wr_locked got %b want 1", locked_o); end
    n_vec++; if (lock_owner_o !== 2'd1) begin n_err++; $display("FAIL lk_owner got %0d want 1", lock_owner_o); end
    n_vec++; if (core_r_valid_o !== 4'b0010) begin n_err++; $display("FAIL lk_rvalid got %b want 0010", core_r_valid_o); end
    advance(1, 0, 0); set_core(1, 1'b0, REG_TRIGGER);
    @(negedge clk);
    n_vec++; if (core_gnt_o !== 4'b0010) begin n_err++; $display("FAIL lk_trig_gnt got %b want 0010", core_gnt_o); end
    n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL lk_trig_locked got %b want 1", locked_o); end
    advance(1, 0, 0); drop_core(1);
    @(negedge clk);
    n_vec++; if (core_gnt_o !== 4'b1000) begin n_err++; $display("FAIL lk_after_gnt got %b want 1000", core_gnt_o); end
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL lk_after_locked got %b want 0", locked_o); end
    advance(1, 0, 0); drop_core(3);
  endtask

  task automatic test_acquire_fail();
    apply_reset();
    set_core(1, 1'b1, REG_ACQUIRE); set_core(2, 1'b1, 3);
    @(negedge clk);
    n_vec++; if (core_gnt_o !== 4'b0010) begin n_err++; $display("FAIL af_gnt got %b want 0010", core_gnt_o); end
    advance(1, 1, 1); drop_core(1);
    @(negedge clk);
    n_vec++; if (slv_req_o !== 1'b0) begin n_err++; $display("FAIL af_pend_req got %b want 0", slv_req_o); end
    n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL af_pend_locked got %b want 1", locked_o); end
    n_vec++; if (core_r_valid_o !== 4'b0010) begin n_err++; $display("FAIL af_rvalid got %b want 0010", core_r_valid_o); end
    n_vec++; if (core_r_data_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL af_rdata got %h want ffffffff", core_r_data_o); end
    advance(0, 0, 0);
    @(negedge clk);
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL af_rel_locked got %b want 0", locked_o); end
    n_vec++; if (core_gnt_o !== 4'b0100) begin n_err++; $display("FAIL af_rel_gnt got %b want 0100", core_gnt_o); end
    advance(1, 0, 0); drop_core(2);
  endtask

  task automatic test_softclear();
    apply_reset();
    set_core(0, 1'b1, REG_ACQUIRE);
    @(negedge clk);
    n_vec++; if (core_gnt_o !== 4'b0001) begin n_err++; $display("FAIL sc_acq_gnt got %b want 0001", core_gnt_o); end
    advance(1, 1, 0); drop_core(0);
    @(negedge clk);
    advance(0, 0, 0);
    set_core(2, 1'b0, REG_SOFTCLEAR); set_core(1, 1'b0, 3);
    @(negedge clk);
    n_vec++; if (locked_o !== 1'b1) begin n_err++; $display("FAIL sc_locked got %b want 1", locked_o); end
    n_vec++; if (lock_owner_o !== 2'd0) begin n_err++; $display("FAIL sc_owner got %0d want 0", lock_owner_o); end
    n_vec++; if (core_gnt_o !== 4'b0100) begin n_err++; $display("FAIL sc_gnt got %b want 0100", core_gnt_o); end
    advance(1, 0, 0); drop_core(2);
    @(negedge clk);
    n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL sc_rel_locked got %b want 0", locked_o); end
    n_vec++; if (core_gnt_o !== 4'b0010) begin n_err++; $display("FAIL sc_rel_gnt got %b want 0010", core_gnt_o); end
    advance(1, 0, 0); drop_core(1);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_g, exp_v;
    apply_reset();
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 3);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_g = '0; exp_g[c % N] = 1'b1;
      exp_v = '0; if (c > 0) exp_v[(c - 1) % N] = 1'b1;
      n_vec++; if (core_gnt_o !== exp_g) begin n_err++; $display("FAIL b2b_gnt c=%0d got %b want %b", c, core_gnt_o, exp_g); end
      n_vec++; if (core_r_valid_o !== exp_v) begin n_err++; $display("FAIL b2b_rvalid c=%0d got %b want %b", c, core_r_valid_o, exp_v); end
      advance(1, 0, 0);
    end
    core_req_i = '0;
  endtask

`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    set_core(1, 1'b1, REG_ACQUIRE); set_core(2, 1'b1, 3);
    @(negedge clk);
    advance(1, 1, 0); drop_core(1);
    @(negedge clk);
    advance(0, 0, 0);
    for (int k = 0; k <= LT; k++) begin
      @(negedge clk);
      if (k < LT) begin
        n_vec++; if ({lock_timeout_o, core_gnt_o} !== 5'b0_0000) begin n_err++; $display("FAIL to_wait k=%0d got %b%b want 0 0000", k, lock_timeout_o, core_gnt_o); end
      end else begin
        n_vec++; if ({lock_timeout_o, core_gnt_o} !== 5'b1_0100) begin n_err++; $display("FAIL to_fire got %b%b want 1 0100", lock_timeout_o, core_gnt_o); end
        n_vec++; if (locked_o !== 1'b0) begin n_err++; $display("FAIL to_locked got %b want 0", locked_o); end
      end
      advance(k == LT, 0, 0);
    end
    drop_core(2);
  endtask
`endif

  // Randomized traffic against a transaction-level model of the arbitration rules.
  task automatic test_random();
    bit rq[N]; bit rw[N];
    logic [AW-1:0] ra[N]; logic [BW-1:0] rb[N]; logic [DW-1:0] rd[N];
    int ptr, owner, w, kind, idx;
    bit held, waiting, nh, nw, el, xfer, acq, fail;
    logic [N-1:0] exp_g, exp_id, exp_v;
    logic [LOG_REGS-1:0] wr;
    apply_reset();
    ptr = 0; owner = 0; held = 0; waiting = 0;
    for (int i = 0; i < N; i++) rq[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = 1; ra[i] = $urandom; rb[i] = BW'($urandom); rd[i] = $urandom;
          rw[i] = 1'($urandom_range(0, 1));
          kind = $urandom_range(0, 11);
          if (kind == 0) begin ra[i][LOG_REGS+1:2] = REG_TRIGGER; rw[i] = 0; end
          else if (kind == 1) begin ra[i][LOG_REGS+1:2] = REG_ACQUIRE; rw[i] = 1; end
          else if (kind == 2) begin ra[i][LOG_REGS+1:2] = REG_SOFTCLEAR; rw[i] = 0; end
          else ra[i][LOG_REGS+1:2] = LOG_REGS'($urandom_range(2, 31));
        end
        core_req_i[i] = rq[i]; core_wen_i[i] = rw[i]; core_add_i[i] = ra[i];
        core_be_i[i] = rb[i]; core_data_i[i] = rd[i];
      end
      slv_gnt_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        el = rq[idx] && (!held || idx == owner || (!rw[idx] && ra[idx][LOG_REGS+1:2] == REG_SOFTCLEAR));
        if (el && w < 0) w = idx;
      end
      exp_g = '0; exp_id = '0;
      if (w >= 0) begin exp_id[w] = 1'b1; exp_g[w] = slv_gnt_i; end
      n_vec++; if (slv_req_o !== (w >= 0)) begin n_err++; $display("FAIL rnd_req cyc=%0d got %b want %b", cyc, slv_req_o, w >= 0); end
      n_vec++; if (core_gnt_o !== exp_g) begin n_err++; $display("FAIL rnd_gnt cyc=%0d got %b want %b", cyc, core_gnt_o, exp_g); end
      n_vec++; if (slv_id_o !== exp_id) begin n_err++; $display("FAIL rnd_id cyc=%0d got %b want %b", cyc, slv_id_o, exp_id); end
      n_vec++; if (locked_o !== held) begin n_err++; $display("FAIL rnd_locked cyc=%0d got %b want %b", cyc, locked_o, held); end
      n_vec++; if (lock_owner_o !== 2'(owner)) begin n_err++; $display("FAIL rnd_owner cyc=%0d got %0d want %0d", cyc, lock_owner_o, owner); end
      if (w >= 0) begin
        n_vec++;
        if ({slv_add_o, slv_wen_o, slv_be_o, slv_data_o} !== {ra[w], rw[w], rb[w], rd[w]}) begin
          n_err++; $display("FAIL rnd_fields cyc=%0d got %h/%b/%h/%h want %h/%b/%h/%h", cyc,
                            slv_add_o, slv_wen_o, slv_be_o, slv_data_o, ra[w], rw[w], rb[w], rd[w]);
        end
      end
      exp_v = '0;
      if (slv_r_valid_i && exp_q.size() > 0) exp_v = exp_q.pop_front();
      n_vec++; if (core_r_valid_o !== exp_v) begin n_err++; $display("FAIL rnd_rvalid cyc=%0d got %b want %b", cyc, core_r_valid_o, exp_v); end
      n_vec++; if (core_r_data_o !== slv_r_data_i) begin n_err++; $display("FAIL rnd_rdata cyc=%0d got %h want %h", cyc, core_r_data_o, slv_r_data_i); end
      xfer = (w >= 0) && slv_gnt_i;
      nh = held; nw = waiting; wr = '0; acq = 0;
      if (waiting && slv_r_valid_i) begin nw = 0; nh = !slv_r_data_i[DW-1]; end
      if (xfer) begin
        wr = ra[w][LOG_REGS+1:2];
        acq = rw[w] && wr == REG_ACQUIRE;
        if (!held && acq) begin nh = 1; nw = 1; owner = w; end
        if (held && !waiting && !rw[w] && wr == REG_TRIGGER && w == owner) nh = 0;
        if (!rw[w] && wr == REG_SOFTCLEAR) begin nh = 0; nw = 0; end
        ptr = (w + 1) % N;
        exp_v = '0; exp_v[w] = 1'b1;
        exp_q.push_back(exp_v);
        rq[w] = 0;
      end
      held = nh; waiting = nw;
      fail = 1'($urandom_range(0, 1));
      advance(xfer, acq, fail);
    end
    core_req_i = '0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_simultaneous();
    test_lock_trigger();
    test_acquire_fail();
    test_softclear();
    test_back_to_back();
`ifdef HWPE_CTRL_ARB_LOCK_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
